// File: rtl/serial_loader_pkg.sv
// Shared types and helpers for the serial word loader.
// SERIAL_PARITY_EN widens the bit counter to hold the trailing parity bit.
package serial_loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    FULL   = 2'd3
  } loader_state_t;

  localparam int unsigned SYNC_STAGES = 2;

  function automatic int unsigned cnt_width(input int unsigned word_w);
`ifdef SERIAL_PARITY_EN
    return $clog2(word_w + 2);
`else
    return $clog2(word_w + 1);
`endif
  endfunction

endpackage

// File: rtl/serial_word_loader_if.sv
// Pin-side inputs and word-side handshake of the serial word loader.
// The bit_count width follows SERIAL_PARITY_EN through the package helper.
interface serial_word_loader_if #(
  parameter int unsigned WORD_W = 16
) ();
  localparam int unsigned CntW = serial_loader_pkg::cnt_width(WORD_W);

  logic              in_bit;
  logic              ready;
  logic              clear;
  logic              word_ack;
  logic [WORD_W-1:0] word_out;
  logic              word_valid;
  logic [CntW-1:0]   bit_count;
  logic              overflow;
  logic              parity_err;

  modport master (
    output in_bit, ready, clear, word_ack,
    input  word_out, word_valid, bit_count, overflow, parity_err
  );

  modport slave (
    input  in_bit, ready, clear, word_ack,
    output word_out, word_valid, bit_count, overflow, parity_err
  );
endinterface

// File: rtl/serial_word_loader_strobe_debouncer.sv
// Synchronises a raw strobe pin, debounces it and emits a one-cycle pulse
// on each debounced rising edge.
module strobe_debouncer
  import serial_loader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic strobe_i,
  output logic rise_o
);
  localparam logic [7:0] Target = 8'(DEBOUNCE_CYC);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rdy_s;
  logic [7:0]             cnt_q, cnt_d;
  logic                   deb_q, deb_d;
  logic                   rise_q, rise_d;

  assign rdy_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (rdy_s != deb_q) begin
      if (cnt_q + 8'd1 == Target) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
    // Pulse registers on the same edge the debounced level rises.
    rise_d = deb_d & ~deb_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      cnt_q  <= '0;
      deb_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], strobe_i};
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
      rise_q <= rise_d;
    end
  end

  assign rise_o = rise_q;
endmodule

// File: rtl/serial_word_loader.sv
// Captures debounced strobe-qualified serial bits MSB-first into a word and
// offers it downstream on a valid/ack handshake. Optional: SERIAL_PARITY_EN.
module serial_word_loader
  import serial_loader_pkg::*;
#(
  parameter int unsigned WORD_W       = 16,
  parameter int unsigned DEBOUNCE_CYC = 4
) (
  input logic                  clock,
  input logic                  reset_n,
  serial_word_loader_if.slave  bus
);
  localparam int unsigned CntW = cnt_width(WORD_W);
  localparam logic [CntW-1:0] FullCnt = CntW'(WORD_W);
`ifdef SERIAL_PARITY_EN
  localparam logic [CntW-1:0] ParCnt = CntW'(WORD_W + 1);
`endif

  logic [SYNC_STAGES-1:0] in_sync_q;
  logic                   in_s;
  logic                   cap_pulse;

  loader_state_t     state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] shift_val;
  logic              valid_q, valid_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
`ifdef SERIAL_PARITY_EN
  logic              perr_q, perr_d;
`endif

  strobe_debouncer #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_rdy_deb (
    .clk_i    (clock),
    .rst_ni   (reset_n),
    .strobe_i (bus.ready),
    .rise_o   (cap_pulse)
  );

  assign in_s      = in_sync_q[SYNC_STAGES-1];
  assign shift_val = {shreg_q[WORD_W-2:0], in_s};

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    word_d  = word_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
`ifdef SERIAL_PARITY_EN
    perr_d  = perr_q;
`endif
    if (bus.clear) begin
      state_d = IDLE;
      shreg_d = '0;
      word_d  = '0;
      valid_d = 1'b0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
`ifdef SERIAL_PARITY_EN
      perr_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (cap_pulse) begin
            shreg_d = shift_val;
            cnt_d   = CntW'(1);
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (cap_pulse) begin
            shreg_d = shift_val;
            cnt_d   = cnt_q + CntW'(1);
            if (cnt_q + CntW'(1) == FullCnt) begin
              word_d  = shift_val;
`ifdef SERIAL_PARITY_EN
              state_d = PARITY;
`else
              valid_d = 1'b1;
              state_d = FULL;
`endif
            end
          end
        end
`ifdef SERIAL_PARITY_EN
        PARITY: begin
          if (cap_pulse) begin
            perr_d  = (^shreg_q) ^ in_s;
            cnt_d   = ParCnt;
            valid_d = 1'b1;
            state_d = FULL;
          end
        end
`endif
        FULL: begin
          // Ack wins over a coincident strobe edge; that edge is dropped.
          if (bus.word_ack) begin
            valid_d = 1'b0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            shreg_d = '0;
`ifdef SERIAL_PARITY_EN
            perr_d  = 1'b0;
`endif
            state_d = IDLE;
          end else if (cap_pulse) begin
            ovf_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_sync_q <= '0;
      state_q   <= IDLE;
      shreg_q   <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
`ifdef SERIAL_PARITY_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      in_sync_q <= {in_sync_q[SYNC_STAGES-2:0], bus.in_bit};
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
`ifdef SERIAL_PARITY_EN
      perr_q    <= perr_d;
`endif
    end
  end

  assign bus.word_out   = word_q;
  assign bus.word_valid = valid_q;
  assign bus.bit_count  = cnt_q;
  assign bus.overflow   = ovf_q;
`ifdef SERIAL_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_serial_word_loader.sv
// Randomised bench for serial_word_loader against a bit-level word model.
// Build with SERIAL_PARITY_EN to exercise the parity state as well.
module tb_serial_word_loader;
  localparam int unsigned W = 16;
  localparam int unsigned D = 4;
`ifdef SERIAL_PARITY_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  serial_word_loader_if #(.WORD_W(W)) bus ();

  serial_word_loader #(
    .WORD_W       (W),
    .DEBOUNCE_CYC (D)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // Reference model: the word in progress as a bit count plus a number.
  int unsigned m_n;
  logic [31:0] m_shift, m_word;
  bit          m_full, m_ovf, m_perr;

  task automatic model_zero(input bit wipe_word);
    m_n = 0; m_shift = 0; m_full = 0; m_ovf = 0; m_perr = 0;
    if (wipe_word) m_word = 0;
  endtask

  task automatic model_cap(input bit b);
    if (m_full) begin
      m_ovf = 1;
    end else if (m_n < W) begin
      m_shift = ((m_shift << 1) | 32'(b)) & ((32'd1 << W) - 1);
      m_n++;
      if (m_n == W) begin
        m_word = m_shift;
        if (!ParEn) m_full = 1;
      end
    end else begin
      m_perr = (^m_word[W-1:0]) ^ b;
      m_n++;
      m_full = 1;
    end
  endtask

  task automatic model_ack();
    if (m_full) model_zero(1'b0);
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".bit_count"}, 32'(bus.bit_count), m_n);
    check_eq({tag, ".word_valid"}, 32'(bus.word_valid), 32'(m_full));
    check_eq({tag, ".word_out"}, 32'(bus.word_out), m_word);
    check_eq({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ovf));
    check_eq({tag, ".parity_err"}, 32'(bus.parity_err), 32'(m_perr));
  endtask

  // One clean strobe: ready high for hi cycles, low for lo cycles. With
  // ack_cap set, word_ack is driven on the edge where the capture lands.
  task automatic send_bit(input bit b, input int hi, input int lo, input bit ack_cap);
    @(negedge clock);
    bus.in_bit = b;
    bus.ready  = 1'b1;
    for (int i = 1; i <= hi; i++) begin
      @(negedge clock);
      if (ack_cap && i == D + 2) bus.word_ack = 1'b1;
      if (i == D + 3) bus.word_ack = 1'b0;
    end
    bus.ready = 1'b0;
    for (int i = 0; i < lo; i++) @(negedge clock);
    if (ack_cap && m_full) model_ack();
    else model_cap(b);
    check_all("bit");
  endtask

  task automatic send_word(input logic [31:0] data, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) send_bit(data[W-1-(nbits-1-i)], 8, 8, 1'b0);
  endtask

  task automatic ack_pulse();
    @(negedge clock);
    bus.word_ack = 1'b1;
    @(negedge clock);
    bus.word_ack = 1'b0;
    model_ack();
    check_all("ack");
  endtask

  task automatic clear_pulse();
    @(negedge clock);
    bus.clear = 1'b1;
    @(negedge clock);
    bus.clear = 1'b0;
    model_zero(1'b1);
    check_all("clear");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w;
    bus.in_bit = 0; bus.ready = 0; bus.clear = 0; bus.word_ack = 0;
    model_zero(1'b1);
    repeat (3) @(negedge clock);
    check_all("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    check_all("post_reset");

    // Nominal word, then ack.
    send_word(32'h0000A5C3, W);
`ifdef SERIAL_PARITY_EN
    send_bit(^16'hA5C3, 8, 8, 1'b0);
`endif
    ack_pulse();

    // Bounce on ready: only the final stable high captures.
    @(negedge clock);
    bus.in_bit = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.ready = ~k[0];
      repeat (2) @(negedge clock);
    end
    bus.ready = 1'b1;
    repeat (6) @(negedge clock);
    bus.ready = 1'b0;
    repeat (10) @(negedge clock);
    model_cap(1'b1);
    check_all("bounce");
    clear_pulse();

    // Overflow in FULL, then ack aligned with a capture edge.
    w = $urandom & 32'hFFFF;
    send_word(w, W);
`ifdef SERIAL_PARITY_EN
    send_bit(1'b1, 8, 8, 1'b0);
`endif
    send_bit(1'b1, 8, 8, 1'b0);
    send_bit(1'b0, 8, 8, 1'b1);
    send_bit(1'b1, 8, 8, 1'b0);

    // Clear mid-word, then a fresh 0x0001.
    clear_pulse();
    send_word(32'h00000000, 7);
    clear_pulse();
    send_word(32'h00000001, W);
`ifdef SERIAL_PARITY_EN
    send_bit(1'b1, 8, 8, 1'b0);
`endif
    ack_pulse();

    // Asynchronous reset mid-word: outputs drop without a clock edge.
    send_word(32'h0000FFFF, 5);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    model_zero(1'b1);
    check_all("async_reset");
    @(negedge clock);
    reset_n = 1'b1;
    send_word(32'h00001234, W);
`ifdef SERIAL_PARITY_EN
    send_bit(1'b0, 8, 8, 1'b0);
`endif
    ack_pulse();

`ifdef SERIAL_PARITY_EN
    send_word(32'h000000FF, W);
    send_bit(1'b0, 8, 8, 1'b0);
    ack_pulse();
    send_word(32'h000000FE, W);
    send_bit(1'b0, 8, 8, 1'b0);
    ack_pulse();
`endif

    // Random mix of bits, stray acks, aligned acks and occasional clears.
    for (int it = 0; it < 150; it++) begin
      int unsigned r;
      r = $urandom_range(0, 31);
      if (r < 2) clear_pulse();
      else if (r < 6) ack_pulse();
      else send_bit(1'($urandom), int'($urandom_range(5, 10)), int'($urandom_range(8, 11)),
                    r < 8);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_word_loader.md
Name: serial_word_loader

Overview:
Upstream input stage of the chip's wrapper. Turns the raw, bouncy switch inputs for the data bit and the strobe into clean, sampled serial bits. Assembles those bits MSB-first into a WORD_W-bit word. Presents the finished word to the downstream mode/display logic over a valid/ack handshake.

Parameters:
WORD_W, 16, data bits per word (2..32)
DEBOUNCE_CYC, 4, consecutive stable cycles needed before the debounced strobe changes level (1..255)

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous reset, active-low
in_bit  input  1  raw serial data bit from a pin
ready  input  1  raw strobe from a pin; each debounced rising edge captures one bit
clear  input  1  synchronous abort; discards the partial word
word_ack  input  1  downstream consumed word_out
word_out  output  WORD_W  assembled word; valid only while word_valid=1
word_valid  output  1  a complete word is held
bit_count  output  $clog2(WORD_W+1)  bits captured in the current word
overflow  output  1  sticky flag: a strobe edge arrived while a word was held
parity_err  output  1  parity mismatch on the held word (see Optional Feature)

Behaviour:
- Reset (reset_n=0, asynchronous): all flops clear, including synchronisers, debouncer and shift register. All outputs are 0. State is IDLE.
- Synchronisers: in_bit and ready each pass through a 2-flop synchroniser (in_s, rdy_s). in_bit is not debounced.
- Debounce:
  - Counter increments each cycle that rdy_s != rdy_deb.
  - Any cycle with rdy_s == rdy_deb resets the counter to 0.
  - When the counter would reach DEBOUNCE_CYC, rdy_deb toggles and the counter resets.
- Edge detect: cap_pulse is a registered one-cycle pulse when rdy_deb goes 0->1.
- Capture latency: a clean rise on ready reaches a bit_count update after 2 + DEBOUNCE_CYC + 1 clock edges.
- States:
  - IDLE: bit_count=0, word_valid=0. cap_pulse shifts in_s into the LSB of the shift register (shreg <= {shreg[W-2:0], in_s}), sets bit_count=1, and moves to SHIFT.
  - SHIFT: each cap_pulse shifts and increments bit_count. On the capture that makes bit_count==WORD_W, word_out is loaded from the completed shift value, word_valid=1 on the next cycle, and the state moves to FULL.
  - FULL: word_out and bit_count=WORD_W hold.
    - A cap_pulse with no word_ack sets overflow=1; the bit is discarded.
    - word_ack=1 gives word_valid=0, bit_count=0, overflow=0 and shreg=0 on the next cycle, and the state moves to IDLE.
- word_ack outside FULL is ignored.
- Simultaneous word_ack and cap_pulse in FULL: the ack is taken and the edge is dropped. overflow is not set and no bit is captured.
- clear=1 in any state has priority over everything: next cycle is IDLE with all outputs 0, including overflow and parity_err. The debouncer and synchronisers are not cleared.
- Reset mid-word: the partial word is lost. No output glitches except the immediate asynchronous drop to 0.
- word_out holds its last value outside FULL; downstream qualifies it with word_valid.

Optional Feature:
- Macro: SERIAL_PARITY_EN.
- When defined, the state machine adds a PARITY state:
  - After WORD_W data bits, one more cap_pulse captures an even-parity bit.
  - word_valid asserts only after that bit, with bit_count=WORD_W+1.
  - parity_err = XOR(data bits, parity bit). It is valid alongside word_valid and clears on ack or clear.
  - bit_count width is $clog2(WORD_W+2).
- When undefined: no PARITY state, and parity_err is tied to 0.

Decomposition:
- Package serial_loader_pkg holds:
  - state enum loader_state_t {IDLE, SHIFT, PARITY, FULL}, with PARITY present but unreachable when the feature is off;
  - localparam SYNC_STAGES=2;
  - a function for the counter width.
- One sub-module, strobe_debouncer: 2-flop sync, debounce counter and registered rise pulse, with parameter DEBOUNCE_CYC. The top instantiates it for ready and uses a plain 2-flop sync for in_bit.

Test Plan:
- Reset: assert reset_n=0 mid-word with bit_count=5 -> all outputs 0 immediately; the next word starts from bit_count=0.
- Nominal word: WORD_W=16, DEBOUNCE_CYC=4; shift 0xA5C3 MSB-first with ready held high for 8 cycles and low for 8 per bit -> word_valid=1 and word_out=0xA5C3 after the 16th edge; ack -> word_valid=0 and bit_count=0 next cycle.
- Bounce rejection: ready toggles 1,0,1,0 with 2-cycle pulses, then is held high for 6 cycles -> exactly one capture (bit_count 0->1).
- Overflow and simultaneous ack: in FULL, pulse ready without ack -> overflow=1 and word_out unchanged. Then align a cap_pulse with word_ack -> IDLE, overflow=0, bit_count=0.
- clear mid-word: after 7 bits, clear=1 -> bit_count=0 next cycle. A fresh 16-bit 0x0001 then loads correctly.
- SERIAL_PARITY_EN: send 0x00FF then parity 0 -> parity_err=0. Send 0x00FE then parity 0 -> parity_err=1, word_valid=1 only after the 17th edge.
